// File: rtl/bola_ctrl_if.sv
// Ball <-> brick/bar/video bus for bola_ctrl.
interface bola_ctrl_if;
  logic [9:0] x_bar;
  logic [9:0] y_bar;
  logic       hit_block;
  logic       hit_block_u;
  logic       hit_block_d;
  logic       hit_block_l;
  logic       hit_block_r;
  logic [9:0] x_ball;
  logic [9:0] y_ball;
  logic [9:0] next_x;
  logic [9:0] next_y;
  logic       dir_x;
  logic       dir_y;

  modport master (
    input  x_bar, y_bar, hit_block, hit_block_u, hit_block_d, hit_block_l, hit_block_r,
    output x_ball, y_ball, next_x, next_y, dir_x, dir_y
  );

  modport slave (
    output x_bar, y_bar, hit_block, hit_block_u, hit_block_d, hit_block_l, hit_block_r,
    input  x_ball, y_ball, next_x, next_y, dir_x, dir_y
  );
endinterface

// File: rtl/bola_ctrl.sv
// Breakout ball motion controller: position, reflection, loss and lives.
// Optional BALL_SPEEDUP_EN shortens the step period on each honoured block hit.
module bola_ctrl #(
  parameter int R_BALL   = 8,
  parameter int H_BAR    = 8,
  parameter int W_BAR    = 64,
  parameter int H_SCREEN = 480,
  parameter int W_SCREEN = 640,
  parameter int X0       = 320,
  parameter int Y0       = 400,
  parameter int TICK_DIV = 200000,
  parameter int LIVES    = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  bola_ctrl_if.master bus,
  output logic        running,
  output logic        lost,
  output logic [1:0]  lives,
  output logic        gameover
);

  typedef enum logic [1:0] {IDLE, MOVE, LOST, OVER} state_t;

  localparam logic [9:0]  X_INIT     = 10'(X0);
  localparam logic [9:0]  Y_INIT     = 10'(Y0);
  localparam logic [9:0]  X_MIN      = 10'(R_BALL);
  localparam logic [9:0]  X_MAX      = 10'(W_SCREEN - 1 - R_BALL);
  localparam logic [9:0]  Y_MIN      = 10'(R_BALL);
  localparam logic [9:0]  Y_LOSS     = 10'(H_SCREEN - 1 - R_BALL);
  localparam logic [10:0] BAR_DY     = 11'(H_BAR + R_BALL);
  localparam logic [10:0] BAR_DX     = 11'(W_BAR);
  localparam logic [19:0] DIV_FULL   = 20'(TICK_DIV);
  localparam logic [1:0]  LIVES_INIT = 2'(LIVES);

  state_t      state_q, state_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        dx_q, dx_d, dy_q, dy_d;
  logic [1:0]  lives_q, lives_d;
  logic        lost_q, lost_d;
  logic [19:0] cnt_q, cnt_d;
  logic        start_q;
  logic [19:0] div_cur;
  logic        launch, tick, bar_y, bar_x;

`ifdef BALL_SPEEDUP_EN
  localparam logic [19:0] DIV_STEP = 20'(TICK_DIV / 8);
  localparam logic [19:0] DIV_MIN  = 20'(TICK_DIV / 4);
  logic [19:0] div_q, div_d;
  assign div_cur = div_q;
`else
  assign div_cur = DIV_FULL;
`endif

  assign launch = start & ~start_q;
  // >= so a divisor shrinking mid-count still terminates the step
  assign tick   = (state_q == MOVE) && (cnt_q >= div_cur - 20'd1);
  // widened compares avoid wrap when the bar sits near an edge
  assign bar_y  = ({1'b0, y_q} + BAR_DY) == {1'b0, bus.y_bar};
  assign bar_x  = (({1'b0, x_q} + BAR_DX) >= {1'b0, bus.x_bar}) &&
                  ({1'b0, x_q} <= ({1'b0, bus.x_bar} + BAR_DX));

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    lives_d = lives_q;
    lost_d  = 1'b0;
    cnt_d   = '0;
`ifdef BALL_SPEEDUP_EN
    div_d   = div_q;
`endif
    case (state_q)
      IDLE: begin
        x_d  = X_INIT;
        y_d  = Y_INIT;
        dx_d = 1'b1;
        dy_d = 1'b0;
        if (launch) state_d = MOVE;
      end
      MOVE: begin
        cnt_d = tick ? '0 : cnt_q + 20'd1;
        if (tick) begin
          if (y_q >= Y_LOSS) begin
            lost_d  = 1'b1;
            lives_d = lives_q - 2'd1;
            state_d = LOST;
`ifdef BALL_SPEEDUP_EN
            div_d   = DIV_FULL;
`endif
          end else begin
            // lowest priority first: block flags, bar, then walls
            if (bus.hit_block) begin
              if (bus.hit_block_u) dy_d = 1'b0;
              if (bus.hit_block_d) dy_d = 1'b1;
              if (bus.hit_block_l) dx_d = 1'b0;
              if (bus.hit_block_r) dx_d = 1'b1;
`ifdef BALL_SPEEDUP_EN
              div_d = (div_q > DIV_MIN + DIV_STEP) ? div_q - DIV_STEP : DIV_MIN;
`endif
            end
            if (bar_y && bar_x && dy_q) dy_d = 1'b0;
            if (x_q <= X_MIN) dx_d = 1'b1;
            if (x_q >= X_MAX) dx_d = 1'b0;
            if (y_q <= Y_MIN) dy_d = 1'b1;
            x_d = dx_d ? x_q + 10'd1 : x_q - 10'd1;
            y_d = dy_d ? y_q + 10'd1 : y_q - 10'd1;
          end
        end
      end
      LOST: begin
        x_d     = X_INIT;
        y_d     = Y_INIT;
        dx_d    = 1'b1;
        dy_d    = 1'b0;
        state_d = (lives_q == 2'd0) ? OVER : IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= X_INIT;
      y_q     <= Y_INIT;
      dx_q    <= 1'b1;
      dy_q    <= 1'b0;
      lives_q <= LIVES_INIT;
      lost_q  <= 1'b0;
      cnt_q   <= '0;
      start_q <= 1'b0;
`ifdef BALL_SPEEDUP_EN
      div_q   <= DIV_FULL;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      lives_q <= lives_d;
      lost_q  <= lost_d;
      cnt_q   <= cnt_d;
      start_q <= start;
`ifdef BALL_SPEEDUP_EN
      div_q   <= div_d;
`endif
    end
  end

  assign bus.x_ball = x_q;
  assign bus.y_ball = y_q;
  assign bus.dir_x  = dx_q;
  assign bus.dir_y  = dy_q;
  assign bus.next_x = dx_q ? x_q + 10'd1 : x_q - 10'd1;
  assign bus.next_y = dy_q ? y_q + 10'd1 : y_q - 10'd1;
  assign running    = (state_q == MOVE);
  assign gameover   = (state_q == OVER);
  assign lost       = lost_q;
  assign lives      = lives_q;

endmodule
